// File: rtl/pipelined_alu_mc.sv
// Execute-stage ALU: single-cycle ops with registered result, plus iterative
// multiply and restoring unsigned divide behind a valid/ready handshake.
module pipelined_alu_mc #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_in_1,
  input  logic [DATA_WIDTH-1:0] alu_in_2,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_bcond,
  output logic                  busy
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_BEQ  = 5'd10, OP_BNE  = 5'd11;
  localparam logic [4:0] OP_BLT  = 5'd12, OP_BGE  = 5'd13, OP_BLTU = 5'd14, OP_BGEU = 5'd15;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [W-1:0] res;
    logic         bcond;
  } alu_rsp_t;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opnd_q;
  logic [1:0]      mc_op_q;
  logic [W-1:0]    res_q;
  logic            bcond_q;
  logic            vld_q;

  alu_rsp_t               sc_rsp;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   lt_s, lt_u, eq, is_mc;

  assign shamt = alu_in_2[SHAMT_WIDTH-1:0];
  assign lt_s  = $signed(alu_in_1) < $signed(alu_in_2);
  assign lt_u  = alu_in_1 < alu_in_2;
  assign eq    = alu_in_1 == alu_in_2;
  assign is_mc = alu_op[4:2] == 3'b100;

  always_comb begin
    sc_rsp = '0;
    case (alu_op)
      OP_ADD:  sc_rsp.res = alu_in_1 + alu_in_2;
      OP_SUB:  sc_rsp.res = alu_in_1 - alu_in_2;
      OP_AND:  sc_rsp.res = alu_in_1 & alu_in_2;
      OP_OR:   sc_rsp.res = alu_in_1 | alu_in_2;
      OP_XOR:  sc_rsp.res = alu_in_1 ^ alu_in_2;
      OP_SLL:  sc_rsp.res = alu_in_1 << shamt;
      OP_SRL:  sc_rsp.res = alu_in_1 >> shamt;
      OP_SRA:  sc_rsp.res = $signed(alu_in_1) >>> shamt;
      OP_SLT:  sc_rsp.res = {{(W-1){1'b0}}, lt_s};
      OP_SLTU: sc_rsp.res = {{(W-1){1'b0}}, lt_u};
      OP_BEQ:  sc_rsp.bcond = eq;
      OP_BNE:  sc_rsp.bcond = ~eq;
      OP_BLT:  sc_rsp.bcond = lt_s;
      OP_BGE:  sc_rsp.bcond = ~lt_s;
      OP_BLTU: sc_rsp.bcond = lt_u;
      OP_BGEU: sc_rsp.bcond = ~lt_u;
      default: ;
    endcase
  end

  // acc_q holds {high, low} for multiply and {remainder, dividend/quotient} for divide
  logic [W:0]   mul_sum, div_trial;
  logic [W-1:0] div_diff, mc_res;
  logic         div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = acc_q[2*W-1:W-1];
    div_diff  = div_trial[W-1:0] - opnd_q;
    div_ge    = div_trial >= {1'b0, opnd_q};
    if (mc_op_q[1])
      acc_d = {(div_ge ? div_diff : div_trial[W-1:0]), acc_q[W-2:0], div_ge};
    else
      acc_d = {mul_sum, acc_q[W-1:1]};
    mc_res = mc_op_q[0] ? acc_d[2*W-1:W] : acc_d[W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      mc_op_q <= '0;
      res_q   <= '0;
      bcond_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_mc) begin
              state_q <= BUSY;
              cnt_q   <= CW'(W);
              mc_op_q <= alu_op[1:0];
              opnd_q  <= alu_op[1] ? alu_in_2 : alu_in_1;
              acc_q   <= {{W{1'b0}}, (alu_op[1] ? alu_in_1 : alu_in_2)};
            end else begin
              res_q   <= sc_rsp.res;
              bcond_q <= sc_rsp.bcond;
              vld_q   <= 1'b1;
            end
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          // last iteration: publish the result on the same edge the counter hits 0
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            res_q   <= mc_res;
            bcond_q <= 1'b0;
            vld_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = state_q == IDLE;
  assign busy       = state_q == BUSY;
  assign out_valid  = vld_q;
  assign alu_result = res_q;
  assign alu_bcond  = bcond_q;
endmodule

// File: tb/tb_pipelined_alu_mc.sv
// Bench for pipelined_alu_mc: 32-bit and 8-bit instances, vector table,
// hand sequences for handshake/reset corners, and random ops vs a reference model.
module tb_pipelined_alu_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv, ir, ov, bc, bz;
  logic [4:0]  op;
  logic [31:0] a, b, res;
  logic        iv8, ir8, ov8, bc8, bz8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, res8;

  int checks = 0;
  int errors = 0;

  pipelined_alu_mc #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .alu_op(op),
    .alu_in_1(a), .alu_in_2(b), .out_valid(ov), .alu_result(res),
    .alu_bcond(bc), .busy(bz));

  pipelined_alu_mc #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .alu_op(op8),
    .alu_in_1(a8), .alu_in_2(b8), .out_valid(ov8), .alu_result(res8),
    .alu_bcond(bc8), .busy(bz8));

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, res;
    logic        bc;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] o, input logic [31:0] x, y, r,
                              input logic c, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.bc = c; v.lat = l;
    return v;
  endfunction

  // Reference: plain integer arithmetic on w-bit values, returns {bcond, result}
  function automatic logic [32:0] ref_alu(input int w, input logic [4:0] o,
                                          input logic [31:0] x, y);
    longint unsigned mask, ux, uy, r;
    longint sx, sy;
    int sh;
    logic c;
    mask = (64'd1 << w) - 64'd1;
    ux = 64'(x) & mask;
    uy = 64'(y) & mask;
    sx = ((ux >> (w - 1)) & 64'd1) != 0 ? longint'(ux) - (longint'(1) << w) : longint'(ux);
    sy = ((uy >> (w - 1)) & 64'd1) != 0 ? longint'(uy) - (longint'(1) << w) : longint'(uy);
    sh = int'(uy % longint'(w));
    r = 0;
    c = 1'b0;
    case (o)
      5'd0:  r = ux + uy;
      5'd1:  r = ux - uy;
      5'd2:  r = ux & uy;
      5'd3:  r = ux | uy;
      5'd4:  r = ux ^ uy;
      5'd5:  r = ux << sh;
      5'd6:  r = ux >> sh;
      5'd7:  r = sx >>> sh;
      5'd8:  r = (sx < sy) ? 1 : 0;
      5'd9:  r = (ux < uy) ? 1 : 0;
      5'd10: c = ux == uy;
      5'd11: c = ux != uy;
      5'd12: c = sx < sy;
      5'd13: c = sx >= sy;
      5'd14: c = ux < uy;
      5'd15: c = ux >= uy;
      5'd16: r = ux * uy;
      5'd17: r = (ux * uy) >> w;
      5'd18: r = (uy == 0) ? mask : ux / uy;
      5'd19: r = (uy == 0) ? ux : ux % uy;
      default: r = 0;
    endcase
    return {c, 32'(r & mask)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
  task automatic run32(input logic [4:0] o, input logic [31:0] x, y, er,
                       input logic eb, input int el, input string nm);
    int lat;
    chk({nm, ".rdy"}, 64'(ir), 64'd1);
    op = o; a = x; b = y; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0; a = ~x; b = ~y; lat = 1;
    while (!ov && lat < 80) begin @(negedge clk); lat++; end
    chk({nm, ".lat"}, 64'(lat), 64'(el));
    chk({nm, ".res"}, 64'(res), 64'(er));
    chk({nm, ".bc"}, 64'(bc), 64'(eb));
  endtask

  task automatic run8(input logic [4:0] o, input logic [7:0] x, y, er,
                      input logic eb, input int el, input string nm);
    int lat;
    chk({nm, ".rdy"}, 64'(ir8), 64'd1);
    op8 = o; a8 = x; b8 = y; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0; a8 = ~x; b8 = ~y; lat = 1;
    while (!ov8 && lat < 40) begin @(negedge clk); lat++; end
    chk({nm, ".lat"}, 64'(lat), 64'(el));
    chk({nm, ".res"}, 64'(res8), 64'(er));
    chk({nm, ".bc"}, 64'(bc8), 64'(eb));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t t8[$];
    int lat, bad, cnt;

    tbl.push_back(mk(5'd0,  32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1));
    tbl.push_back(mk(5'd1,  32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1));
    tbl.push_back(mk(5'd7,  32'h80000000, 32'h24, 32'hF8000000, 1'b0, 1));
    tbl.push_back(mk(5'd2,  32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1));
    tbl.push_back(mk(5'd3,  32'hF0F0, 32'h0FF0, 32'hFFF0, 1'b0, 1));
    tbl.push_back(mk(5'd4,  32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0, 1));
    tbl.push_back(mk(5'd5,  32'h1, 32'h21, 32'h2, 1'b0, 1));
    tbl.push_back(mk(5'd12, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1));
    tbl.push_back(mk(5'd14, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1));
    tbl.push_back(mk(5'd15, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1));
    tbl.push_back(mk(5'd13, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1));
    tbl.push_back(mk(5'd8,  32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1));
    tbl.push_back(mk(5'd9,  32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1));
    tbl.push_back(mk(5'd10, 32'h5, 32'h5, 32'h0, 1'b1, 1));
    tbl.push_back(mk(5'd11, 32'h5, 32'h5, 32'h0, 1'b0, 1));
    tbl.push_back(mk(5'd25, 32'h1234, 32'h5678, 32'h0, 1'b0, 1));
    tbl.push_back(mk(5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 33));
    tbl.push_back(mk(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33));
    tbl.push_back(mk(5'd18, 32'd100, 32'd7, 32'd14, 1'b0, 33));
    tbl.push_back(mk(5'd19, 32'd100, 32'd7, 32'd2, 1'b0, 33));
    tbl.push_back(mk(5'd18, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 33));
    tbl.push_back(mk(5'd19, 32'd5, 32'd0, 32'd5, 1'b0, 33));
    tbl.push_back(mk(5'd18, 32'd3, 32'd10, 32'd0, 1'b0, 33));
    tbl.push_back(mk(5'd19, 32'd3, 32'd10, 32'd3, 1'b0, 33));
    tbl.push_back(mk(5'd0,  32'd7, 32'd8, 32'd15, 1'b0, 1));

    t8.push_back(mk(5'd0,  32'hF0, 32'h20, 32'h10, 1'b0, 1));
    t8.push_back(mk(5'd16, 32'h10, 32'h10, 32'h00, 1'b0, 9));
    t8.push_back(mk(5'd17, 32'h10, 32'h10, 32'h01, 1'b0, 9));
    t8.push_back(mk(5'd5,  32'h01, 32'h09, 32'h02, 1'b0, 1));
    t8.push_back(mk(5'd18, 32'h00, 32'h00, 32'hFF, 1'b0, 9));
    t8.push_back(mk(5'd7,  32'h80, 32'h0F, 32'hFF, 1'b0, 1));

    reset = 1'b1;
    iv = 1'b0; op = '0; a = '0; b = '0;
    iv8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    #12;
    chk("rst.res", 64'(res), 64'd0);
    chk("rst.ov", 64'(ov), 64'd0);
    chk("rst.bc", 64'(bc), 64'd0);
    chk("rst.rdy", 64'(ir), 64'd1);
    chk("rst.busy", 64'(bz), 64'd0);
    chk("rst.rdy8", 64'(ir8), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i])
      run32(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].bc, tbl[i].lat,
            $sformatf("v32_%0d", i));

    // back-to-back single-cycle stream: results on consecutive cycles
    @(negedge clk);
    op = 5'd0; a = 32'hFFFFFFFF; b = 32'h1; iv = 1'b1;
    @(negedge clk);
    chk("s0.ov", 64'(ov), 64'd1);
    chk("s0.res", 64'(res), 64'h0);
    op = 5'd1; a = 32'h0; b = 32'h1;
    @(negedge clk);
    chk("s1.ov", 64'(ov), 64'd1);
    chk("s1.res", 64'(res), 64'hFFFFFFFF);
    op = 5'd7; a = 32'h80000000; b = 32'h24;
    @(negedge clk);
    iv = 1'b0;
    chk("s2.ov", 64'(ov), 64'd1);
    chk("s2.res", 64'(res), 64'hF8000000);
    @(negedge clk);
    chk("s3.ov", 64'(ov), 64'd0);

    // in_valid raised while busy must be ignored
    op = 5'd16; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0; lat = 1; bad = 0;
    while (!ov && lat < 80) begin
      if (ir || !bz) bad++;
      if (lat == 3) begin iv = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1; end
      if (lat == 5) iv = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("bsy.rdy", 64'(bad), 64'd0);
    chk("bsy.lat", 64'(lat), 64'd33);
    chk("bsy.res", 64'(res), 64'd1);
    chk("bsy.rdyout", 64'(ir), 64'd1);
    @(negedge clk);
    chk("bsy.ign", 64'(ov), 64'd0);

    // reset mid-MUL aborts without out_valid
    op = 5'd16; a = 32'd7; b = 32'd9; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rm.res", 64'(res), 64'd0);
    chk("rm.ov", 64'(ov), 64'd0);
    chk("rm.busy", 64'(bz), 64'd0);
    chk("rm.rdy", 64'(ir), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin @(negedge clk); if (ov) cnt++; end
    chk("rm.nov", 64'(cnt), 64'd0);
    run32(5'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1, "rm.add");

    foreach (t8[i])
      run8(t8[i].op, t8[i].a[7:0], t8[i].b[7:0], t8[i].res[7:0], t8[i].bc, t8[i].lat,
           $sformatf("v8_%0d", i));

    for (int i = 0; i < 60; i++) begin
      logic [4:0]  o;
      logic [31:0] x, y;
      logic [32:0] e;
      o = 5'($urandom_range(0, 31));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 7) == 0) y = x;
      e = ref_alu(32, o, x, y);
      run32(o, x, y, e[31:0], e[32], (o >= 5'd16 && o <= 5'd19) ? 33 : 1,
            $sformatf("r32_%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  o;
      logic [7:0]  x, y;
      logic [32:0] e;
      o = 5'($urandom_range(0, 31));
      x = 8'($urandom);
      y = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) y = x;
      e = ref_alu(8, o, {24'd0, x}, {24'd0, y});
      run8(o, x, y, e[7:0], e[32], (o >= 5'd16 && o <= 5'd19) ? 9 : 1,
           $sformatf("r8_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
